// File: rtl/cpu_gen2.sv
`default_nettype none
// ============================================================================
// Module   : cpu_gen2
// Brief    : Small accumulator-style CPU with four registers, Z/G/C flags,
//            on-chip instruction/data memories and a return-address stack.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_gen2 #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMEM_DEPTH   = 32,
  parameter int DMEM_DEPTH   = 32,
  parameter int STACK_DEPTH  = 4,
  parameter bit START_HALTED = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [8+DATA_WIDTH-1:0]       prog_wdata,
  output logic                          halted,
  output logic                          fault,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic [4*DATA_WIDTH-1:0]       regs_dbg
);

  localparam int c_iw  = 8 + DATA_WIDTH;
  localparam int c_pw  = $clog2(IMEM_DEPTH);
  localparam int c_aw  = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam int c_spw = $clog2(STACK_DEPTH + 1);
  localparam int c_sw  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [1:0] c_st_run  = 2'd0;
  localparam logic [1:0] c_st_mem2 = 2'd1;
  localparam logic [1:0] c_st_halt = 2'd2;

  logic [c_iw-1:0]       r_imem  [IMEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_dmem  [DMEM_DEPTH];
  logic [c_pw-1:0]       r_stack [STACK_DEPTH];
  logic [DATA_WIDTH-1:0] r_regs  [4];
  logic                  r_z, r_g, r_c;
  logic [c_pw-1:0]       r_pc;
  logic [c_spw-1:0]      r_sp;
  logic [DATA_WIDTH-1:0] r_buf;
  logic                  r_fault;
  logic [1:0]            r_state;

  logic [c_iw-1:0]       w_instr;
  logic [7:0]            w_op;
  logic [DATA_WIDTH-1:0] w_opnd;
  logic [1:0]            w_rd;
  logic [DATA_WIDTH-1:0] w_a, w_rsv, w_src, w_alu_res;
  logic                  w_alu_c;
  logic [31:0]           w_opnd32;
  logic [c_pw-1:0]       w_tgt, w_pc_inc;
  logic [c_aw-1:0]       w_daddr;
  logic                  w_stk_full, w_stk_empty, w_push, w_dmem_we, w_imem_we;
  logic [c_sw-1:0]       w_sp_wr, w_sp_top;

  assign w_instr  = r_imem[r_pc];
  assign w_op     = w_instr[c_iw-1 -: 8];
  assign w_opnd   = w_instr[DATA_WIDTH-1:0];
  assign w_rd     = w_op[7:6];
  assign w_a      = r_regs[w_rd];
  assign w_rsv    = r_regs[w_opnd[1:0]];
  assign w_opnd32 = 32'(w_opnd);
  assign w_tgt    = c_pw'(w_opnd32 % 32'(IMEM_DEPTH));
  assign w_daddr  = c_aw'(w_opnd32 % 32'(DMEM_DEPTH));
  assign w_pc_inc = (r_pc == c_pw'(IMEM_DEPTH - 1)) ? '0 : r_pc + c_pw'(1);

  assign w_stk_full  = (r_sp == c_spw'(STACK_DEPTH));
  assign w_stk_empty = (r_sp == '0);
  assign w_sp_wr     = c_sw'(r_sp);
  assign w_sp_top    = c_sw'(r_sp - c_spw'(1));

  assign w_push    = (r_state == c_st_run) && (w_op == 8'h0B) && !w_stk_full;
  assign w_dmem_we = (r_state == c_st_mem2) && (w_op[5:0] == 6'h02);
  assign w_imem_we = (r_state == c_st_halt) && prog_we;

  // ALU: shifts are unary on the selected source operand
  always_comb begin
    w_src     = w_op[4] ? w_rsv : w_opnd;
    w_alu_c   = 1'b0;
    w_alu_res = w_src;
    case (w_op[3:0])
      4'h0: {w_alu_c, w_alu_res} = {1'b0, w_a} + {1'b0, w_src};
      4'h1: {w_alu_c, w_alu_res} = {1'b0, w_a} - {1'b0, w_src};
      4'h2: w_alu_res = w_a & w_src;
      4'h3: w_alu_res = w_a | w_src;
      4'h4: w_alu_res = w_a ^ w_src;
      4'h5: begin
        w_alu_c   = w_src[DATA_WIDTH-1];
        w_alu_res = {w_src[DATA_WIDTH-2:0], 1'b0};
      end
      4'h6: begin
        w_alu_c   = w_src[0];
        w_alu_res = {1'b0, w_src[DATA_WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      r_z     <= 1'b0;
      r_g     <= 1'b0;
      r_c     <= 1'b0;
      r_pc    <= '0;
      r_sp    <= '0;
      r_buf   <= '0;
      r_fault <= 1'b0;
      r_state <= START_HALTED ? c_st_halt : c_st_run;
    end else begin
      case (r_state)
        c_st_halt: begin
          if (start) begin
            r_pc    <= '0;
            r_fault <= 1'b0;
            r_sp    <= '0;
            r_state <= c_st_run;
          end
        end
        c_st_mem2: begin
          if (w_op[5:0] == 6'h01) r_regs[w_rd] <= r_buf;
          r_pc    <= w_pc_inc;
          r_state <= c_st_run;
        end
        default: begin
          if (w_op[5]) begin
            r_regs[w_rd] <= w_alu_res;
            r_z          <= (w_alu_res == '0);
            r_c          <= w_alu_c;
            r_g          <= 1'b0;
            r_pc         <= w_pc_inc;
          end else begin
            case (w_op[5:0])
              6'h08: begin r_regs[w_rd] <= w_opnd; r_pc <= w_pc_inc; end
              6'h18: begin r_regs[w_rd] <= w_rsv;  r_pc <= w_pc_inc; end
              6'h03: begin
                r_z  <= (w_a == w_rsv);
                r_g  <= ($signed(w_a) > $signed(w_rsv));
                r_c  <= (w_a < w_rsv);
                r_pc <= w_pc_inc;
              end
              6'h01: begin r_buf <= r_dmem[w_daddr]; r_state <= c_st_mem2; end
              6'h02: begin r_buf <= w_a;             r_state <= c_st_mem2; end
              default: begin
                // control flow decodes the full opcode byte; anything else is a NOP
                case (w_op)
                  8'h04: r_state <= c_st_halt;
                  8'h05: r_pc <= w_tgt;
                  8'h06: r_pc <= r_z  ? w_tgt : w_pc_inc;
                  8'h07: r_pc <= !r_z ? w_tgt : w_pc_inc;
                  8'h09: r_pc <= r_g  ? w_tgt : w_pc_inc;
                  8'h0A: r_pc <= r_c  ? w_tgt : w_pc_inc;
                  8'h0B: begin
                    if (w_stk_full) begin
                      r_fault <= 1'b1;
                      r_state <= c_st_halt;
                    end else begin
                      r_sp <= r_sp + c_spw'(1);
                      r_pc <= w_tgt;
                    end
                  end
                  8'h0C: begin
                    if (w_stk_empty) begin
                      r_fault <= 1'b1;
                      r_state <= c_st_halt;
                    end else begin
                      r_sp <= r_sp - c_spw'(1);
                      r_pc <= r_stack[w_sp_top];
                    end
                  end
                  default: r_pc <= w_pc_inc;
                endcase
              end
            endcase
          end
        end
      endcase
    end
  end

  // Memories carry no reset so their contents survive rst
  always_ff @(posedge clk) begin
    if (w_push) r_stack[w_sp_wr] <= w_pc_inc;
  end

  always_ff @(posedge clk) begin
    if (w_dmem_we) r_dmem[w_daddr] <= r_buf;
  end

  always_ff @(posedge clk) begin
    if (w_imem_we) r_imem[prog_addr] <= prog_wdata;
  end

  assign halted   = (r_state == c_st_halt);
  assign fault    = r_fault;
  assign pc       = r_pc;
  assign regs_dbg = {r_regs[3], r_regs[2], r_regs[1], r_regs[0]};

endmodule
`default_nettype wire

// File: tb/tb_cpu_gen2.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_gen2
// Brief    : Self-checking bench for cpu_gen2 (program table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_gen2;

  localparam int NV = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [4:0]  prog_addr = '0;
  logic [15:0] prog_wdata = '0;
  logic        halted, fault;
  logic [4:0]  pc;
  logic [31:0] regs_dbg;

  cpu_gen2 #(
    .DATA_WIDTH(8), .IMEM_DEPTH(32), .DMEM_DEPTH(32),
    .STACK_DEPTH(2), .START_HALTED(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .halted(halted), .fault(fault), .pc(pc), .regs_dbg(regs_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] regs;
    logic        flt;
    logic [4:0]  pcv;
    logic        chk_pc;
    int          cyc;
  } exp_t;

  exp_t        vexp [NV];
  logic [15:0] progs [NV][32];
  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put(int v, int a, logic [7:0] op, logic [7:0] opnd);
    progs[v][a] = {op, opnd};
  endtask

  task automatic set_exp(int v, string n, logic [31:0] r, int c);
    vexp[v] = '{name: n, regs: r, flt: 1'b0, pcv: 5'd0, chk_pc: 1'b0, cyc: c};
  endtask

  task automatic build();
    for (int v = 0; v < NV; v++)
      for (int a = 0; a < 32; a++) progs[v][a] = 16'h0000;
    put(0,0,8'h08,8'h05); put(0,1,8'h20,8'hFD); put(0,2,8'h04,8'h00);
    set_exp(0, "v0_add_carry", 32'h0000_0002, 3);
    put(1,0,8'h08,8'h05); put(1,1,8'h20,8'hFD); put(1,2,8'h06,8'h06);
    put(1,3,8'h0A,8'h05); put(1,4,8'h04,8'h00); put(1,5,8'h48,8'h11); put(1,6,8'h04,8'h00);
    set_exp(1, "v1_flags_zc", 32'h0000_1102, 6);
    put(2,0,8'h48,8'h7F); put(2,1,8'h42,8'h03); put(2,2,8'h81,8'h03); put(2,3,8'h04,8'h00);
    set_exp(2, "v2_store_load", 32'h007F_7F00, 6);
    put(3,0,8'h48,8'hFF); put(3,1,8'h08,8'h01); put(3,2,8'h03,8'h01); put(3,3,8'h0A,8'h05);
    put(3,4,8'h04,8'h00); put(3,5,8'h09,8'h07); put(3,6,8'h04,8'h00); put(3,7,8'hC8,8'h77);
    put(3,8,8'h06,8'h0A); put(3,9,8'h04,8'h00); put(3,10,8'hC8,8'hEE); put(3,11,8'h04,8'h00);
    set_exp(3, "v3_cmp_signed", 32'h7700_FF01, 8);
    put(4,0,8'h08,8'h03); put(4,1,8'h21,8'h05); put(4,2,8'h48,8'hF0); put(4,3,8'h62,8'h3C);
    put(4,4,8'h88,8'h81); put(4,5,8'hB5,8'h02); put(4,6,8'h0A,8'h08); put(4,7,8'h04,8'h00);
    put(4,8,8'hC8,8'h55); put(4,9,8'hE4,8'hFF); put(4,10,8'hE3,8'h01); put(4,11,8'h04,8'h00);
    set_exp(4, "v4_alu_mix", 32'hAB02_30FE, 11);
    put(5,0,8'h08,8'h03); put(5,1,8'h48,8'h00); put(5,2,8'h60,8'h02); put(5,3,8'h21,8'h01);
    put(5,4,8'h07,8'h02); put(5,5,8'h76,8'h01); put(5,6,8'h76,8'h01); put(5,7,8'h0A,8'h09);
    put(5,8,8'h04,8'h00); put(5,9,8'h98,8'h01); put(5,10,8'h04,8'h00);
    set_exp(5, "v5_loop_shr", 32'h0001_0100, 16);
    put(6,0,8'h0B,8'h04); put(6,1,8'hE7,8'h33); put(6,2,8'h04,8'h00); put(6,4,8'h0B,8'h07);
    put(6,5,8'h0C,8'h00); put(6,7,8'h0F,8'h05); put(6,8,8'h88,8'h22); put(6,9,8'h0C,8'h00);
    set_exp(6, "v6_call_ret", 32'h3322_0000, 8);
    put(7,0,8'h0A,8'h03); put(7,1,8'h08,8'h09); put(7,2,8'h05,8'h3F); put(7,31,8'h61,8'h01);
    put(7,3,8'h88,8'hC3); put(7,4,8'h04,8'h00);
    set_exp(7, "v7_pc_wrap", 32'h00C3_FF09, 7);
    put(8,0,8'h01,8'h23); put(8,1,8'h04,8'h00);
    set_exp(8, "v8_dmem_kept", 32'h0000_007F, 3);
  endtask

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic load_word(int a, logic [15:0] w);
    prog_we = 1'b1; prog_addr = 5'(a); prog_wdata = w;
    step(1);
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int c0, output int c);
    c = c0;
    while (!halted && c < 300) begin
      step(1);
      c++;
    end
    if (!halted) begin
      n_cmp++; n_bad++;
      $display("FAIL halt_timeout: got running expected halted");
    end
  endtask

  task automatic score(int c);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      check({e.name, "_regs"},   regs_dbg, e.regs);
      check({e.name, "_fault"},  32'(fault), 32'(e.flt));
      check({e.name, "_cycles"}, 32'(c), 32'(e.cyc));
      if (e.chk_pc) check({e.name, "_pc"}, 32'(pc), 32'(e.pcv));
    end
  endtask

  initial begin
    build();
    do_reset();
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_fault",  32'(fault),  32'd0);
    check("rst_pc",     32'(pc),     32'd0);
    check("rst_regs",   regs_dbg,    32'd0);

    for (int v = 0; v < NV; v++) begin
      do_reset();
      for (int a = 0; a < 32; a++) load_word(a, progs[v][a]);
      sb.push_back(vexp[v]);
      pulse_start();
      wait_halt(0, cyc);
      score(cyc);
    end

    // Stack overflow on third nested CALL, then restart must clear the stack
    do_reset();
    load_word(0, 16'h0B01); load_word(1, 16'h0B02);
    load_word(2, 16'h0B03); load_word(3, 16'h0400);
    sb.push_back('{name: "h1_overflow", regs: 32'h0, flt: 1'b1, pcv: 5'd2, chk_pc: 1'b1, cyc: 3});
    pulse_start();
    wait_halt(0, cyc);
    score(cyc);
    sb.push_back('{name: "h1_restart", regs: 32'h0, flt: 1'b1, pcv: 5'd2, chk_pc: 1'b1, cyc: 3});
    pulse_start();
    check("h1_start_fault",  32'(fault),  32'd0);
    check("h1_start_pc",     32'(pc),     32'd0);
    check("h1_start_halted", 32'(halted), 32'd0);
    wait_halt(0, cyc);
    score(cyc);

    do_reset();
    load_word(0, 16'h0C00);
    sb.push_back('{name: "h2_underflow", regs: 32'h0, flt: 1'b1, pcv: 5'd0, chk_pc: 1'b1, cyc: 1});
    pulse_start();
    wait_halt(0, cyc);
    score(cyc);

    // rst while LOAD sits in its second cycle
    do_reset();
    load_word(0, 16'h485A); load_word(1, 16'h4205);
    load_word(2, 16'h0105); load_word(3, 16'h0400);
    pulse_start();
    step(4);
    check("h3_pc_in_load", 32'(pc), 32'd2);
    rst = 1'b1;
    #1;
    check("h3_async_halt", 32'(halted), 32'd1);
    step(1);
    rst = 1'b0;
    check("h3_regs_after_abort", regs_dbg, 32'd0);

    // rst while STORE sits in its second cycle: dmem[5] keeps 0x5A
    load_word(0, 16'h48A5); load_word(1, 16'h4205); load_word(2, 16'h0400);
    pulse_start();
    step(2);
    check("h3b_pc_in_store", 32'(pc), 32'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    load_word(0, 16'h0105); load_word(1, 16'h0400);
    sb.push_back('{name: "h3b_store_abort", regs: 32'h5A, flt: 1'b0, pcv: 5'd0, chk_pc: 1'b0, cyc: 3});
    pulse_start();
    wait_halt(0, cyc);
    score(cyc);

    // prog_we alongside start is honoured; prog_we while running is not
    do_reset();
    load_word(1, 16'h0400);
    prog_we = 1'b1; prog_addr = 5'd0; prog_wdata = 16'h0842; start = 1'b1;
    step(1);
    start = 1'b0; prog_addr = 5'd1; prog_wdata = 16'h0899;
    sb.push_back('{name: "h4_prog_start", regs: 32'h42, flt: 1'b0, pcv: 5'd0, chk_pc: 1'b0, cyc: 2});
    step(1);
    prog_we = 1'b0;
    wait_halt(1, cyc);
    score(cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
